// File: rtl/uart_frame_rx_if.sv
// Frame-side bus of uart_frame_rx: assembled frame word, ready/ack handshake and status flags.
// master = receiver, slave = consumer.
interface uart_frame_rx_if #(
  parameter int DW = 40
) ();
  logic          frame_ack;
  logic          frame_ready;
  logic [DW-1:0] frame_data;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;

  modport master (input frame_ack, output frame_ready, frame_data, frame_err, parity_err, overrun);
  modport slave  (output frame_ack, input frame_ready, frame_data, frame_err, parity_err, overrun);
endinterface

// File: rtl/uart_frame_rx.sv
// Oversampling UART receiver packing FRAME_BYTES characters into one frame word; results 1 cycle after mid-stop.
// The line never stalls: an unacked frame is overwritten and overrun is flagged until the next ack.
module uart_frame_rx #(
  parameter int DATA_BITS    = 8,
  parameter int FRAME_BYTES  = 5,
  parameter int OVERSAMPLE   = 16,
  parameter int PARITY       = 0,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            uart_in,
  uart_frame_rx_if.master fr
);
  localparam int FW = FRAME_BYTES * DATA_BITS;
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam int BW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT_BITS * OVERSAMPLE + 1);
  localparam logic [OW-1:0] HALF_CNT  = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] FULL_CNT  = OW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(FRAME_BYTES - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_BITS * OVERSAMPLE);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state_q, state_d;

  logic                 rx_meta, rx_s;
  logic [OW-1:0]        os_cnt;
  logic [CW-1:0]        bit_cnt;
  logic [BW-1:0]        byte_idx;
  logic [TW-1:0]        to_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [FW-1:0]        asm_q, asm_next, frame_data_q;
  logic                 frame_ready_q, overrun_q, frame_err_q, parity_err_q;
  logic                 os_clr, data_smp, par_smp, stop_smp;
  logic                 par_ok, char_ok, frame_done, ack_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {rx_meta, rx_s} <= 2'b11;
    else        {rx_meta, rx_s} <= {uart_in, rx_meta};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    os_clr   = 1'b0;
    data_smp = 1'b0;
    par_smp  = 1'b0;
    stop_smp = 1'b0;
    unique case (state_q)
      IDLE:  if (!rx_s) begin
               state_d = START;
               os_clr  = 1'b1;
             end
      // A start bit that is gone by mid-bit is a glitch: drop it silently.
      START: if (os_cnt == HALF_CNT) begin
               os_clr  = 1'b1;
               state_d = rx_s ? IDLE : DATA;
             end
      DATA:  if (os_cnt == FULL_CNT) begin
               os_clr   = 1'b1;
               data_smp = 1'b1;
               if (bit_cnt == LAST_BIT) state_d = (PARITY != 0) ? PAR : STOP;
             end
      PAR:   if (os_cnt == FULL_CNT) begin
               os_clr  = 1'b1;
               par_smp = 1'b1;
               state_d = STOP;
             end
      STOP:  if (os_cnt == FULL_CNT) begin
               os_clr   = 1'b1;
               stop_smp = 1'b1;
               state_d  = IDLE;
             end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    par_ok = 1'b1;
    if (PARITY == 1)      par_ok = ~(^shreg ^ par_bit);
    else if (PARITY == 2) par_ok = ^shreg ^ par_bit;
    char_ok    = stop_smp && rx_s && par_ok;
    frame_done = char_ok && (byte_idx == LAST_BYTE);
    ack_take   = fr.frame_ack && frame_ready_q;
    asm_next   = asm_q;
    for (int k = 0; k < FRAME_BYTES; k++) begin
      if (byte_idx == BW'(k)) asm_next[k*DATA_BITS +: DATA_BITS] = shreg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt        <= '0;
      bit_cnt       <= '0;
      byte_idx      <= '0;
      to_cnt        <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      asm_q         <= '0;
      frame_data_q  <= '0;
      frame_ready_q <= 1'b0;
      overrun_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
    end else begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;

      if (os_clr || state_q == IDLE) os_cnt <= '0;
      else                           os_cnt <= os_cnt + OW'(1);

      if (state_q != DATA) bit_cnt <= '0;
      else if (data_smp)   bit_cnt <= bit_cnt + CW'(1);

      if (data_smp) shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
      if (par_smp)  par_bit <= rx_s;

      // Idle-time watchdog only runs while a partial frame is waiting.
      if (state_q != IDLE || !rx_s || byte_idx == '0 || to_cnt == TO_LIMIT) to_cnt <= '0;
      else                                                                   to_cnt <= to_cnt + TW'(1);

      if (stop_smp) begin
        if (!char_ok || byte_idx == LAST_BYTE) byte_idx <= '0;
        else                                   byte_idx <= byte_idx + BW'(1);
        if (char_ok)     asm_q        <= asm_next;
        if (!rx_s)       frame_err_q  <= 1'b1;
        else if (!par_ok) parity_err_q <= 1'b1;
      end else if (to_cnt == TO_LIMIT) begin
        byte_idx <= '0;
      end

      // A coincident ack consumes the old frame, so the new one is not an overrun.
      if (frame_done) begin
        frame_data_q  <= asm_next;
        frame_ready_q <= 1'b1;
        if (ack_take)           overrun_q <= 1'b0;
        else if (frame_ready_q) overrun_q <= 1'b1;
      end else if (ack_take) begin
        frame_ready_q <= 1'b0;
        overrun_q     <= 1'b0;
      end
    end
  end

  assign fr.frame_ready = frame_ready_q;
  assign fr.frame_data  = frame_data_q;
  assign fr.frame_err   = frame_err_q;
  assign fr.parity_err  = parity_err_q;
  assign fr.overrun     = overrun_q;
endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: an 8-n-1 / 5-byte instance (A) and a 7-o-1 / 2-byte instance (B),
// checked against a byte-queue model of the character and frame rules.
`timescale 1ns/1ps
module tb_uart_frame_rx;
  localparam int OS   = 16;
  localparam int TO   = 20;
  localparam int DB_A = 8;
  localparam int FB_A = 5;
  localparam int DB_B = 7;
  localparam int FB_B = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ua    = 1'b1;
  logic ub    = 1'b1;

  int          checks = 0;
  int          failures = 0;
  int          ferr_cnt[2] = '{0, 0};
  int          perr_cnt[2] = '{0, 0};
  int          exp_ferr[2];
  int          exp_perr[2];
  logic        exp_rdy[2];
  logic        exp_ovr[2];
  logic [63:0] exp_data[2];
  logic [8:0]  pend_a[$];
  logic [8:0]  pend_b[$];
  longint      cyc = 0;
  longint      last_end[2];

  uart_frame_rx_if #(.DW(DB_A*FB_A)) fa ();
  uart_frame_rx_if #(.DW(DB_B*FB_B)) fb ();

  uart_frame_rx dut_a (.clk(clk), .rst_n(rst_n), .uart_in(ua), .fr(fa.master));
  uart_frame_rx #(.DATA_BITS(DB_B), .FRAME_BYTES(FB_B), .OVERSAMPLE(OS), .PARITY(2), .TIMEOUT_BITS(TO))
    dut_b (.clk(clk), .rst_n(rst_n), .uart_in(ub), .fr(fb.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fa.frame_err)  ferr_cnt[0]++;
    if (fb.frame_err)  ferr_cnt[1]++;
    if (fa.parity_err) perr_cnt[0]++;
    if (fb.parity_err) perr_cnt[1]++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] dut_data(input int w);
    return (w == 0) ? 64'(fa.frame_data) : 64'(fb.frame_data);
  endfunction
  function automatic logic dut_rdy(input int w);
    return (w == 0) ? fa.frame_ready : fb.frame_ready;
  endfunction
  function automatic logic dut_ovr(input int w);
    return (w == 0) ? fa.overrun : fb.overrun;
  endfunction
  function automatic logic [1:0] dut_errs(input int w);
    return (w == 0) ? {fa.frame_err, fa.parity_err} : {fb.frame_err, fb.parity_err};
  endfunction

  task automatic set_line(input int w, input logic v);
    if (w == 0) ua = v; else ub = v;
  endtask
  task automatic set_ack(input int w, input logic v);
    if (w == 0) fa.frame_ack = v; else fb.frame_ack = v;
  endtask

  function automatic int pend_size(input int w);
    return (w == 0) ? pend_a.size() : pend_b.size();
  endfunction
  task automatic pend_clear(input int w);
    if (w == 0) pend_a.delete(); else pend_b.delete();
  endtask
  function automatic logic [63:0] pack(input int w);
    logic [63:0] r;
    r = '0;
    if (w == 0) foreach (pend_a[i]) r |= 64'(pend_a[i]) << (i * DB_A);
    else        foreach (pend_b[i]) r |= 64'(pend_b[i]) << (i * DB_B);
    return r;
  endfunction

  // Drive one character: start, data LSB first, odd parity on B, stop.
  task automatic send_line(input int w, input logic [8:0] d, input bit bad_par, input bit bad_stop);
    int         nb, n;
    logic       p;
    logic [11:0] seq;
    nb  = (w == 0) ? DB_A : DB_B;
    seq = '0;
    p   = 1'b1;
    for (int i = 0; i < nb; i++) begin
      seq[1+i] = d[i];
      p        = p ^ d[i];
    end
    n = 1 + nb;
    if (w != 0) begin
      seq[n] = p ^ bad_par;
      n++;
    end
    seq[n] = ~bad_stop;
    n++;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      set_line(w, seq[i]);
      repeat (OS) @(posedge clk);
      #1;
    end
    set_line(w, 1'b1);
  endtask

  // Send a character and apply the frame rules to the model; ack_mid lands the ack on the mid-stop edge.
  task automatic tx(input int w, input logic [8:0] d, input bit bad_par, input bit bad_stop, input bit ack_mid);
    int         n, nb, fbytes;
    logic [8:0] m;
    bit         done;
    nb     = (w == 0) ? DB_A : DB_B;
    fbytes = (w == 0) ? FB_A : FB_B;
    n      = (w == 0) ? (DB_A + 2) : (DB_B + 3);
    m      = d & ((9'h1 << nb) - 9'h1);
    if (cyc - last_end[w] >= longint'(TO * OS)) pend_clear(w);
    fork
      send_line(w, d, bad_par, bad_stop);
      begin
        if (ack_mid) begin
          @(posedge clk);
          repeat (10 + OS * (n - 1)) @(posedge clk);
          #1 set_ack(w, 1'b1);
          @(posedge clk);
          #1 set_ack(w, 1'b0);
        end
      end
    join
    last_end[w] = cyc;
    done = 1'b0;
    if (bad_stop) begin
      exp_ferr[w]++;
      pend_clear(w);
    end else if (w != 0 && bad_par) begin
      exp_perr[w]++;
      pend_clear(w);
    end else begin
      if (w == 0) pend_a.push_back(m); else pend_b.push_back(m);
      if (pend_size(w) == fbytes) begin
        done        = 1'b1;
        exp_data[w] = pack(w);
        exp_ovr[w]  = ack_mid ? 1'b0 : (exp_ovr[w] | exp_rdy[w]);
        exp_rdy[w]  = 1'b1;
        pend_clear(w);
      end
    end
    if (ack_mid && !done) begin
      exp_rdy[w] = 1'b0;
      exp_ovr[w] = 1'b0;
    end
  endtask

  task automatic chk_all(input int w, input string tag);
    @(negedge clk);
    chk({tag, ".ready"},   64'(dut_rdy(w)), 64'(exp_rdy[w]));
    chk({tag, ".overrun"}, 64'(dut_ovr(w)), 64'(exp_ovr[w]));
    chk({tag, ".data"},    dut_data(w),     exp_data[w]);
    chk({tag, ".ferrs"},   64'(ferr_cnt[w]), 64'(exp_ferr[w]));
    chk({tag, ".perrs"},   64'(perr_cnt[w]), 64'(exp_perr[w]));
  endtask

  task automatic chk_zero(input int w, input string tag);
    chk({tag, ".ready"},   64'(dut_rdy(w)),  64'd0);
    chk({tag, ".overrun"}, 64'(dut_ovr(w)),  64'd0);
    chk({tag, ".data"},    dut_data(w),      64'd0);
    chk({tag, ".errs"},    64'(dut_errs(w)), 64'd0);
  endtask

  task automatic ack(input int w, input string tag);
    @(posedge clk); #1 set_ack(w, 1'b1);
    @(negedge clk);
    chk({tag, ".ack_cycle_ready"}, 64'(dut_rdy(w)), 64'(exp_rdy[w]));
    @(posedge clk); #1 set_ack(w, 1'b0);
    exp_rdy[w] = 1'b0;
    exp_ovr[w] = 1'b0;
    @(negedge clk);
    chk({tag, ".after_ready"},   64'(dut_rdy(w)), 64'd0);
    chk({tag, ".after_overrun"}, 64'(dut_ovr(w)), 64'd0);
  endtask

  task automatic idle_bits(input int nbits);
    repeat (nbits * OS) @(posedge clk);
  endtask

  task automatic frame_seq(input int w, input int first, input int step, input bit ack_last);
    int fbytes;
    fbytes = (w == 0) ? FB_A : FB_B;
    for (int i = 0; i < fbytes; i++)
      tx(w, 9'(first + i * step), 1'b0, 1'b0, ack_last && (i == fbytes - 1));
  endtask

  task automatic frame_rand(input int w);
    int fbytes;
    fbytes = (w == 0) ? FB_A : FB_B;
    for (int i = 0; i < fbytes; i++) tx(w, 9'($urandom_range(0, 511)), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      exp_rdy[w]  = 1'b0;
      exp_ovr[w]  = 1'b0;
      exp_data[w] = '0;
      pend_clear(w);
    end
  endtask

  initial begin
    fa.frame_ack = 1'b0;
    fb.frame_ack = 1'b0;
    for (int w = 0; w < 2; w++) begin
      exp_ferr[w] = 0;
      exp_perr[w] = 0;
      last_end[w] = 0;
    end
    model_reset();

    // Reset values, during and after reset
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_zero(0, "reset_a");
    chk_zero(1, "reset_b");
    #1 rst_n = 1'b1;
    idle_bits(2);
    chk_all(0, "post_reset_a");

    // Basic 5-byte frame
    frame_seq(0, 'h11, 'h11, 1'b0);
    chk_all(0, "basic");
    chk("basic.const", dut_data(0), 64'h55_4433_2211);
    ack(0, "basic_ack");

    // 4-cycle low glitch on an idle line
    @(posedge clk); #1 ua = 1'b0;
    repeat (4) @(posedge clk);
    #1 ua = 1'b1;
    idle_bits(2);
    chk_all(0, "glitch");
    frame_rand(0);
    chk_all(0, "glitch_frame");
    ack(0, "glitch_ack");

    // Bad stop bit on the third character drops the partial frame
    tx(0, 9'h0C, 1'b0, 1'b0, 1'b0);
    tx(0, 9'h0D, 1'b0, 1'b0, 1'b0);
    tx(0, 9'h0E, 1'b0, 1'b1, 1'b0);
    idle_bits(1);
    chk_all(0, "bad_stop");
    frame_seq(0, 'hA0, 1, 1'b0);
    chk_all(0, "bad_stop_frame");
    chk("bad_stop.const", dut_data(0), 64'hA4_A3A2_A1A0);
    ack(0, "bad_stop_ack");

    // Odd parity, 7 data bits, 2-byte frames
    tx(1, 9'h41, 1'b1, 1'b0, 1'b0);
    idle_bits(1);
    chk_all(1, "parity_bad");
    tx(1, 9'h41, 1'b0, 1'b0, 1'b0);
    tx(1, 9'h42, 1'b0, 1'b0, 1'b0);
    chk_all(1, "parity_frame");
    chk("parity.const", dut_data(1), 64'h2141);
    ack(1, "parity_ack");
    for (int i = 0; i < 6; i++) tx(1, 9'($urandom_range(0, 127)), 1'(i == 2), 1'b0, 1'b0);
    idle_bits(1);
    chk_all(1, "parity_rand");

    // Overrun, then ack exactly on the completing edge
    frame_rand(0);
    frame_rand(0);
    chk_all(0, "overrun");
    ack(0, "overrun_ack");
    frame_rand(0);
    chk_all(0, "pre_coincide");
    frame_seq(0, 'h30, 7, 1'b1);
    chk_all(0, "ack_coincide");
    ack(0, "coincide_ack");

    // Inter-byte timeout discards a partial frame silently
    frame_seq(0, 'hE0, 1, 1'b0);
    frame_seq(0, 'h70, 3, 1'b0);
    chk_all(0, "timeout_pre");
    ack(0, "timeout_pre_ack");
    tx(0, 9'h01, 1'b0, 1'b0, 1'b0);
    tx(0, 9'h02, 1'b0, 1'b0, 1'b0);
    tx(0, 9'h03, 1'b0, 1'b0, 1'b0);
    idle_bits(21);
    chk_all(0, "timeout_idle");
    frame_rand(0);
    chk_all(0, "timeout_frame");
    ack(0, "timeout_ack");

    // Random characters, stop errors and gaps on A
    for (int it = 0; it < 40; it++) begin
      logic [8:0] d;
      bit         bs;
      int         g;
      d  = 9'($urandom_range(0, 255));
      bs = ($urandom_range(0, 9) == 0);
      tx(0, d, 1'b0, bs, 1'b0);
      chk_all(0, "rand");
      if (exp_rdy[0]) ack(0, "rand_ack");
      g = ($urandom_range(0, 7) == 0) ? $urandom_range(22, 26) : $urandom_range(bs ? 1 : 0, 3);
      idle_bits(g);
    end

    // Reset mid-character with a frame pending
    frame_rand(0);
    tx(0, 9'h99, 1'b0, 1'b0, 1'b0);
    fork
      send_line(0, 9'h5A, 1'b0, 1'b0);
      begin
        repeat (70) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_zero(0, "midreset_a");
        chk_zero(1, "midreset_b");
      end
    join
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    idle_bits(2);
    chk_all(0, "after_midreset");
    frame_rand(0);
    chk_all(0, "after_midreset_frame");
    ack(0, "after_midreset_ack");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
